// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcodes, functs,
// ALU codes and datapath mux selects.
package multicycle_controller_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    localparam logic [1:0] SRCB_RT   = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_SEXT = 2'd2;
    localparam logic [1:0] SRCB_ZEXT = 2'd3;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT) || (fn == FN_JR);
            OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_XORI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_control_decode.sv
// ALU opcode selection and legality check; outside EXEC the ALU only ever
// adds (PC+4 in FETCH, branch target in DECODE).
module alu_control_decode
    import multicycle_controller_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_signal,
    output logic       legal
);

    always_comb begin
        alu_signal = ALU_ADD;
        legal      = is_legal(opcode, funct);
        if (state == ST_EXEC) begin
            case (opcode)
                OP_RTYPE: begin
                    case (funct)
                        FN_SUB:  alu_signal = ALU_SUB;
                        FN_SLT:  alu_signal = ALU_SLT;
                        default: alu_signal = ALU_ADD;
                    endcase
                end
                // branches compare rs/rt by XOR so alu_zero means equal
                OP_XORI, OP_BEQ, OP_BNE: alu_signal = ALU_XOR;
                default:                 alu_signal = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: steps each instruction through FETCH/DECODE/
// EXEC/MEM/WB, drives datapath controls, counts retirements, traps illegal codes.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                pc_wr_en,
    output logic                ir_wr_en,
    output logic                mem_rd_en,
    output logic                wr_en_memory,
    output logic                wr_en_reg,
    output logic [2:0]          ALU_Signal,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic                write_to_rt,
    output logic                write_reg_31,
    output logic                write_pc8_to_reg,
    output logic                write_from_memory_to_reg,
    output logic [2:0]          state,
    output logic                illegal_instr,
    output logic [RETIRE_W-1:0] instr_retired
);

    localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic                illegal_q;
    logic [RETIRE_W-1:0] retired_q;
    logic                retire, trap, legal, taken;
    logic [2:0]          alu_sig;

    alu_control_decode u_alu_dec (
        .state      (state_q),
        .opcode     (opcode),
        .funct      (funct),
        .alu_signal (alu_sig),
        .legal      (legal)
    );

    assign taken = ((opcode == OP_BEQ) && alu_zero) || ((opcode == OP_BNE) && !alu_zero);

    always_comb begin
        state_d                  = state_q;
        retire                   = 1'b0;
        trap                     = 1'b0;
        pc_wr_en                 = 1'b0;
        ir_wr_en                 = 1'b0;
        mem_rd_en                = 1'b0;
        wr_en_memory             = 1'b0;
        wr_en_reg                = 1'b0;
        alu_src_a                = 1'b0;
        alu_src_b                = SRCB_RT;
        pc_src                   = PC_ALU;
        write_to_rt              = 1'b0;
        write_reg_31             = 1'b0;
        write_pc8_to_reg         = 1'b0;
        write_from_memory_to_reg = 1'b0;
        ALU_Signal               = alu_sig;
        case (state_q)
            ST_FETCH: begin
                mem_rd_en = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_wr_en = 1'b1;
                    pc_wr_en = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_SEXT;
                if (!legal) begin
                    trap    = 1'b1;
                    state_d = ST_HALT;
                end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
                    pc_wr_en         = 1'b1;
                    pc_src           = PC_JUMP;
                    wr_en_reg        = (opcode == OP_JAL);
                    write_reg_31     = (opcode == OP_JAL);
                    write_pc8_to_reg = (opcode == OP_JAL);
                    retire           = 1'b1;
                    state_d          = ST_FETCH;
                end else if ((opcode == OP_RTYPE) && (funct == FN_JR)) begin
                    pc_wr_en = 1'b1;
                    pc_src   = PC_RS;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = ST_WB;
                case (opcode)
                    OP_RTYPE:     alu_src_b = SRCB_RT;
                    OP_ADDI:      alu_src_b = SRCB_SEXT;
                    OP_XORI:      alu_src_b = SRCB_ZEXT;
                    OP_LW, OP_SW: begin
                        alu_src_b = SRCB_SEXT;
                        state_d   = ST_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        alu_src_b = SRCB_RT;
                        pc_wr_en  = taken;
                        pc_src    = taken ? PC_ALUOUT : PC_ALU;
                        retire    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    default: begin
                        trap    = 1'b1;
                        state_d = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                mem_rd_en    = (opcode == OP_LW);
                wr_en_memory = (opcode != OP_LW);
                if (mem_ready) begin
                    retire  = (opcode != OP_LW);
                    state_d = (opcode == OP_LW) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                wr_en_reg                = 1'b1;
                write_to_rt              = (opcode != OP_RTYPE);
                write_from_memory_to_reg = (opcode == OP_LW);
                retire                   = 1'b1;
                state_d                  = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: begin
                trap    = 1'b1;
                state_d = ST_HALT;
            end
        endcase
        // reset must silence every control at once, including a pending memory request
        if (!reset_n) begin
            pc_wr_en                 = 1'b0;
            ir_wr_en                 = 1'b0;
            mem_rd_en                = 1'b0;
            wr_en_memory             = 1'b0;
            wr_en_reg                = 1'b0;
            ALU_Signal               = ALU_ADD;
            alu_src_a                = 1'b0;
            alu_src_b                = SRCB_RT;
            pc_src                   = PC_ALU;
            write_to_rt              = 1'b0;
            write_reg_31             = 1'b0;
            write_pc8_to_reg         = 1'b0;
            write_from_memory_to_reg = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (trap)
                illegal_q <= 1'b1;
            if (retire)
                retired_q <= retired_q + RETIRE_ONE;
        end
    end

    assign state         = state_q;
    assign illegal_instr = illegal_q;
    assign instr_retired = retired_q;

endmodule
